// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: controller for a 12-hour BCD time counter.
//
// Purpose:
//   - Divides clk into a one-cycle tick enable (ena) every DIV cycles while running.
//   - Button-driven set-time FSM: btn_mode enters edit mode and then steps through
//     hours -> minutes -> AM/PM -> commit. btn_inc bumps the field being edited.
//   - Commit issues a one-cycle load strobe with the edited time. Seconds load as 00.
//   - Display digits show live time in RUN and the edit registers otherwise.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   btn_mode, btn_inc     debounced one-cycle button pulses
//   cur_pm/hh/mm/ss       live time from the counter (BCD)
//   ena                   counter tick enable (one-cycle pulse)
//   load, load_pm/hh/mm/ss   load strobe and values for the counter
//   field                 0 none, 1 hours, 2 minutes, 3 AM/PM
//   disp_pm/hh/mm/ss      display digits (combinational mux)
module clock_set_ctrl #(
  parameter int DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       cur_pm,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic       ena,
  output logic       load,
  output logic       load_pm,
  output logic [7:0] load_hh,
  output logic [7:0] load_mm,
  output logic [7:0] load_ss,
  output logic [1:0] field,
  output logic       disp_pm,
  output logic [7:0] disp_hh,
  output logic [7:0] disp_mm,
  output logic [7:0] disp_ss
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [2:0] {RUN, SET_HH, SET_MM, SET_PM, COMMIT} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          ena_q;
  logic          load_q;
  logic          load_pm_q;
  logic [7:0]    load_hh_q;
  logic [7:0]    load_mm_q;
  logic [1:0]    field_q;
  logic          e_pm_q;
  logic [7:0]    e_hh_q;
  logic [7:0]    e_mm_q;

  // Hours run 01..12 then wrap to 01.
  function automatic logic [7:0] bcd_inc_hh(input logic [7:0] v);
    if (v == 8'h12)          return 8'h01;
    else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'h1};
  endfunction

  // Minutes run 00..59 then wrap to 00; no carry into hours.
  function automatic logic [7:0] bcd_inc_mm(input logic [7:0] v);
    if (v == 8'h59)          return 8'h00;
    else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'h1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      ena_q     <= 1'b0;
      load_q    <= 1'b0;
      load_pm_q <= 1'b0;
      load_hh_q <= 8'h12;
      load_mm_q <= 8'h00;
      field_q   <= 2'd0;
      e_pm_q    <= 1'b0;
      e_hh_q    <= 8'h12;
      e_mm_q    <= 8'h00;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (btn_mode) begin
            // Leaving RUN: clear the prescaler so no tick leaks into edit mode.
            state_q <= SET_HH;
            field_q <= 2'd1;
            e_hh_q  <= cur_hh;
            e_mm_q  <= cur_mm;
            e_pm_q  <= cur_pm;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
          end else begin
            cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            ena_q <= (cnt_q == CNT_MAX);
          end
        end
        SET_HH: begin
          cnt_q <= '0;
          ena_q <= 1'b0;
          if (btn_mode) begin
            state_q <= SET_MM;
            field_q <= 2'd2;
          end else if (btn_inc) begin
            e_hh_q <= bcd_inc_hh(e_hh_q);
          end
        end
        SET_MM: begin
          cnt_q <= '0;
          ena_q <= 1'b0;
          if (btn_mode) begin
            state_q <= SET_PM;
            field_q <= 2'd3;
          end else if (btn_inc) begin
            e_mm_q <= bcd_inc_mm(e_mm_q);
          end
        end
        SET_PM: begin
          cnt_q <= '0;
          ena_q <= 1'b0;
          if (btn_mode) begin
            state_q   <= COMMIT;
            field_q   <= 2'd0;
            load_q    <= 1'b1;
            load_hh_q <= e_hh_q;
            load_mm_q <= e_mm_q;
            load_pm_q <= e_pm_q;
          end else if (btn_inc) begin
            e_pm_q <= ~e_pm_q;
          end
        end
        COMMIT: begin
          // The commit cycle counts as prescaler cycle 0, so the first tick
          // lands DIV cycles after the load strobe. Buttons are ignored here.
          state_q <= RUN;
          field_q <= 2'd0;
          cnt_q   <= CW'(1);
          ena_q   <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          field_q <= 2'd0;
          cnt_q   <= '0;
          ena_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ena     = ena_q;
  assign load    = load_q;
  assign load_pm = load_pm_q;
  assign load_hh = load_hh_q;
  assign load_mm = load_mm_q;
  assign load_ss = 8'h00;
  assign field   = field_q;

  always_comb begin
    disp_pm = cur_pm;
    disp_hh = cur_hh;
    disp_mm = cur_mm;
    disp_ss = cur_ss;
    if (state_q != RUN) begin
      disp_pm = e_pm_q;
      disp_hh = e_hh_q;
      disp_mm = e_mm_q;
      disp_ss = 8'h00;
    end
  end

endmodule
